// File: rtl/wptr_ctrl_if.sv
// Write-side bus bundle for wptr_ctrl: write request, read-domain Gray pointer,
// almost-full threshold, overflow clear and all pointer/flag outputs.
// master = write client / surrounding FIFO logic, slave = wptr_ctrl.
interface wptr_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              w_en;
  logic [ADDR_W:0]   g_rptr_async;
  logic [ADDR_W:0]   afull_level;
  logic              ovf_clr;
  logic              w_ack;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W:0]   b_wptr;
  logic [ADDR_W:0]   g_wptr;
  logic [ADDR_W:0]   wcount;
  logic              full;
  logic              almost_full;
  logic              overflow;

  modport master (
    output w_en, g_rptr_async, afull_level, ovf_clr,
    input  w_ack, w_addr, b_wptr, g_wptr, wcount, full, almost_full, overflow
  );

  modport slave (
    input  w_en, g_rptr_async, afull_level, ovf_clr,
    output w_ack, w_addr, b_wptr, g_wptr, wcount, full, almost_full, overflow
  );
endinterface

// File: rtl/wptr_ctrl.sv
// wptr_ctrl: write-domain pointer controller for the async FIFO.
// Synchronises the read-domain Gray pointer through SYNC_STAGES flops (2..4),
// keeps binary/Gray write pointers, a registered fill level, full and
// almost-full flags, and the RAM write address. ADDR_W must be at least 2.
// Optional macro WPTR_OVF_EN builds the sticky overflow register; without it
// overflow is tied low and ovf_clr is ignored.
module wptr_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        w_clk,
  input  logic        wrst,
  wptr_ctrl_if.slave  bus
);

  localparam int PW = ADDR_W + 1;

  // Gray code to binary: each bit is the XOR of all Gray bits at or above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to Gray code.
  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  logic [PW-1:0] sync_r [SYNC_STAGES];
  logic [PW-1:0] b_wptr_r;
  logic [PW-1:0] g_wptr_r;
  logic [PW-1:0] wcount_r;
  logic          full_r;
  logic          afull_r;

  logic          w_ack_s;
  logic [PW-1:0] g_rptr_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] b_wptr_next_s;
  logic [PW-1:0] g_wptr_next_s;
  logic [PW-1:0] level_s;
  logic [PW-1:0] full_match_s;
  logic          full_next_s;
  logic          afull_next_s;

  // Read pointer as seen through the synchroniser; flags compare against this stale copy.
  assign g_rptr_s = sync_r[SYNC_STAGES-1];
  assign rbin_s   = gray2bin(g_rptr_s);

  // Next-state arithmetic for pointers and flags.
  always_comb begin
    w_ack_s       = bus.w_en & ~full_r & ~wrst;
    b_wptr_next_s = b_wptr_r + {{ADDR_W{1'b0}}, w_ack_s};
    g_wptr_next_s = bin2gray(b_wptr_next_s);
    level_s       = b_wptr_next_s - rbin_s;
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_match_s  = {~g_rptr_s[ADDR_W:ADDR_W-1], g_rptr_s[ADDR_W-2:0]};
    full_next_s   = (g_wptr_next_s == full_match_s);
    afull_next_s  = (level_s >= bus.afull_level);
  end

  // Multi-flop synchroniser for the read-domain Gray pointer.
  always_ff @(posedge w_clk) begin
    if (wrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {PW{1'b0}};
      end
    end else begin
      sync_r[0] <= bus.g_rptr_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Pointer, fill-level and flag registers.
  always_ff @(posedge w_clk) begin
    if (wrst) begin
      b_wptr_r <= {PW{1'b0}};
      g_wptr_r <= {PW{1'b0}};
      wcount_r <= {PW{1'b0}};
      full_r   <= 1'b0;
      afull_r  <= 1'b0;
    end else begin
      b_wptr_r <= b_wptr_next_s;
      g_wptr_r <= g_wptr_next_s;
      wcount_r <= level_s;
      full_r   <= full_next_s;
      afull_r  <= afull_next_s;
    end
  end

`ifdef WPTR_OVF_EN
  logic overflow_r;

  // Sticky overflow: set by a refused write, cleared by ovf_clr; a new event wins over clear.
  always_ff @(posedge w_clk) begin
    if (wrst) begin
      overflow_r <= 1'b0;
    end else if (bus.w_en & full_r) begin
      overflow_r <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign bus.overflow = overflow_r;
`else
  logic ovf_clr_unused_s;

  assign ovf_clr_unused_s = bus.ovf_clr;
  assign bus.overflow     = 1'b0;
`endif

  assign bus.w_ack       = w_ack_s;
  assign bus.w_addr      = b_wptr_r[ADDR_W-1:0];
  assign bus.b_wptr      = b_wptr_r;
  assign bus.g_wptr      = g_wptr_r;
  assign bus.wcount      = wcount_r;
  assign bus.full        = full_r;
  assign bus.almost_full = afull_r;

endmodule

// File: tb/tb_wptr_ctrl.sv
// Self-checking bench for wptr_ctrl (ADDR_W=3, SYNC_STAGES=2).
// A count-based reference model (writes accepted, read position, lagged view
// of the read position) predicts every output after each clock edge.
module tb_wptr_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int MOD   = 16;

  logic clk = 1'b0;
  logic wrst;

  wptr_ctrl_if #(.ADDR_W(AW)) bus ();

  wptr_ctrl #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .w_clk (clk),
    .wrst  (wrst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: pointer position, fill level, flags.
  int   m_b;
  int   m_wcount;
  bit   m_full;
  bit   m_af;
  bit   m_ovf;
  int   h_val[$];
  bit   h_rst[$];
  logic [3:0] prev_g;

  typedef struct {
    bit rst; bit en; int rd; int afl;
    bit ack; int b; int wc; bit full; bit af;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check w_ack, clock, advance the model, check all outputs.
  task automatic step(input bit rst, input bit en, input int rd, input int afl,
                      input bit clr, output bit got_ack);
    bit exp_ack;
    bit full_before;
    int rsync;
    int rdm;
    rdm = rd % MOD;
    @(negedge clk);
    wrst             = rst;
    bus.w_en         = en;
    bus.g_rptr_async = 4'(rdm ^ (rdm >> 1));
    bus.afull_level  = 4'(afl);
    bus.ovf_clr      = clr;
    #1;
    exp_ack = en && !m_full && !rst;
    got_ack = bus.w_ack;
    check("w_ack", bus.w_ack, exp_ack);
    @(posedge clk);
    #1;
    // The flags see the read position driven two edges ago, or 0 just after a reset.
    if (h_rst.size() < 2) rsync = 0;
    else if (h_rst[h_rst.size()-1] || h_rst[h_rst.size()-2]) rsync = 0;
    else rsync = h_val[h_val.size()-2];
    full_before = m_full;
    if (rst) begin
      m_b = 0; m_wcount = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      m_b      = (m_b + (exp_ack ? 1 : 0)) % MOD;
      m_wcount = (m_b - rsync + MOD) % MOD;
      m_full   = (m_wcount == DEPTH);
      m_af     = (m_wcount >= afl);
`ifdef WPTR_OVF_EN
      if (en && full_before) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
`endif
    end
    h_rst.push_back(rst);
    h_val.push_back(rdm);
    if (h_rst.size() > 4) begin
      void'(h_rst.pop_front());
      void'(h_val.pop_front());
    end
    check("b_wptr",      bus.b_wptr,      m_b);
    check("w_addr",      bus.w_addr,      m_b % DEPTH);
    check("g_wptr",      bus.g_wptr,      m_b ^ (m_b >> 1));
    check("wcount",      bus.wcount,      m_wcount);
    check("full",        bus.full,        m_full);
    check("almost_full", bus.almost_full, m_af);
    check("overflow",    bus.overflow,    m_ovf);
    if (!rst) check("g_wptr_one_bit", ($countones(bus.g_wptr ^ prev_g) <= 1), 1);
    prev_g = bus.g_wptr;
  endtask

  initial begin
    bit   ack;
    int   tot;
    int   rd;
    int   afl;
    int   wraps;
    bit   full_seen;
    logic [3:0] prev_b;
    bit   ovf_exp;

`ifdef WPTR_OVF_EN
    ovf_exp = 1'b1;
`else
    ovf_exp = 1'b0;
`endif

    wrst = 1'b1; bus.w_en = 1'b0; bus.g_rptr_async = 4'd0;
    bus.afull_level = 4'd6; bus.ovf_clr = 1'b0;
    m_b = 0; m_wcount = 0; m_full = 0; m_af = 0; m_ovf = 0; prev_g = 4'd0;

    // Reset with w_en high, fill with read pointer at 0 (afl=6), then drain read pointer to 3.
    //              rst en rd afl  ack b  wc full af
    tbl[0]  = '{1'b1, 1'b1, 0, 6, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 0, 6, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 0, 6, 1'b1, 1, 1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 0, 6, 1'b1, 2, 2, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 0, 6, 1'b1, 3, 3, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 0, 6, 1'b1, 4, 4, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 0, 6, 1'b1, 5, 5, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 0, 6, 1'b1, 6, 6, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 0, 6, 1'b1, 7, 7, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 0, 6, 1'b1, 8, 8, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 0, 6, 1'b0, 8, 8, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 0, 6, 1'b0, 8, 8, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 3, 6, 1'b0, 8, 8, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 3, 6, 1'b0, 8, 8, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 3, 6, 1'b0, 8, 5, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].rd, tbl[i].afl, 1'b0, ack);
      check("tbl_ack",    ack,             tbl[i].ack);
      check("tbl_b_wptr", bus.b_wptr,      tbl[i].b);
      check("tbl_wcount", bus.wcount,      tbl[i].wc);
      check("tbl_full",   bus.full,        tbl[i].full);
      check("tbl_afull",  bus.almost_full, tbl[i].af);
      if (i == 9) check("tbl_g_wptr_full", bus.g_wptr, 12);
    end

    // Overflow: clear, refill to full, refused write, hold, clear, set-wins-over-clear.
    step(1'b0, 1'b0, 3, 6, 1'b1, ack);
    check("ovf_cleared", bus.overflow, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3, 6, 1'b0, ack);
    check("ovf_refill_full", bus.full, 1);
    step(1'b0, 1'b1, 3, 6, 1'b0, ack);
    check("ovf_ack", ack, 0);
    check("ovf_b_hold", bus.b_wptr, 11);
    check("ovf_set", bus.overflow, ovf_exp);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 3, 6, 1'b0, ack);
    check("ovf_sticky", bus.overflow, ovf_exp);
    step(1'b0, 1'b0, 3, 6, 1'b1, ack);
    check("ovf_clr_pulse", bus.overflow, 0);
    step(1'b0, 1'b1, 3, 6, 1'b1, ack);
    check("ovf_set_wins", bus.overflow, ovf_exp);
    step(1'b0, 1'b0, 3, 6, 1'b1, ack);
    check("ovf_clr_again", bus.overflow, 0);

    // Wrap: 40 writes with the read pointer trailing by 4 entries.
    step(1'b1, 1'b0, 0, 15, 1'b0, ack);
    step(1'b1, 1'b0, 0, 15, 1'b0, ack);
    tot = 0; wraps = 0; full_seen = 1'b0; prev_b = bus.b_wptr;
    for (int i = 0; i < 40; i++) begin
      rd = (tot >= 4) ? tot - 4 : 0;
      step(1'b0, 1'b1, rd, 15, 1'b0, ack);
      if (ack) tot++;
      if (bus.b_wptr < prev_b) wraps++;
      prev_b = bus.b_wptr;
      if (bus.full) full_seen = 1'b1;
    end
    check("wrap_writes", tot, 40);
    check("wrap_count", wraps, 2);
    check("wrap_no_full", full_seen, 0);

    // Randomised traffic with occasional resets, threshold changes and clears.
    tot = 0; rd = 0; afl = 6;
    step(1'b1, 1'b0, 0, afl, 1'b0, ack);
    for (int i = 0; i < 600; i++) begin
      bit r_rst, r_en, r_clr;
      r_rst = ($urandom_range(0, 79) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_clr = ($urandom_range(0, 9) == 0);
      if (rd < tot && $urandom_range(0, 2) == 0) rd++;
      if ($urandom_range(0, 19) == 0) afl = $urandom_range(0, 10);
      step(r_rst, r_en, rd, afl, r_clr, ack);
      if (r_rst) begin
        tot = 0; rd = 0;
      end else if (ack) begin
        tot++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
